// File: rtl/fast_frame_ctrl.sv
// fast_frame_ctrl: frame sequencer feeding the FAST 7x7 window generator.
// Accepts one DMA frame, checks its length, then flushes zero pixels so the pipeline drains.
module fast_frame_ctrl #(
  parameter int COL_NUM      = 640,
  parameter int ROW_NUM      = 480,
  parameter int PIXEL_WIDTH  = 8,
  parameter int FLUSH_CYCLES = 1940
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PIXEL_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_ce,
  output logic                   pix_flush,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_len
);
  localparam int XW = COL_NUM > 1 ? $clog2(COL_NUM) : 1;
  localparam int YW = ROW_NUM > 1 ? $clog2(ROW_NUM) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(COL_NUM - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROW_NUM - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t                 r_state;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [FW-1:0]          r_fcnt;
  logic [PIXEL_WIDTH-1:0] r_pix_data;
  logic                   r_pix_ce;
  logic                   r_pix_flush;
  logic                   r_err_len;
  logic                   w_acc;
  logic                   w_final;
  logic                   w_eof;
  assign w_acc      = s_tvalid & s_tready;
  assign w_final    = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_eof      = w_acc & (s_tlast | w_final);
  assign s_tready   = r_state == RUN;
  assign busy       = r_state != IDLE;
  assign frame_done = r_state == DONE;
  assign pix_data   = r_pix_data;
  assign pix_ce     = r_pix_ce;
  assign pix_flush  = r_pix_flush;
  assign err_len    = r_err_len;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_fcnt      <= '0;
      r_pix_data  <= '0;
      r_pix_ce    <= 1'b0;
      r_pix_flush <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_pix_ce    <= 1'b0;
      r_pix_flush <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_x     <= '0;
        r_y     <= '0;
        r_fcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_state   <= RUN;
            r_x       <= '0;
            r_y       <= '0;
            r_err_len <= 1'b0;
          end
          RUN: if (w_acc) begin
            r_pix_ce   <= 1'b1;
            r_pix_data <= s_tdata;
            r_x        <= r_x == X_LAST ? '0 : r_x + 1'b1;
            r_y        <= r_x == X_LAST ? r_y + 1'b1 : r_y;
            // tlast must coincide exactly with the geometric last pixel
            if (s_tlast != w_final) r_err_len <= 1'b1;
            if (w_eof) begin
              r_state <= FLUSH;
              r_x     <= '0;
              r_y     <= '0;
              r_fcnt  <= '0;
            end
          end
          FLUSH: begin
            r_pix_ce    <= 1'b1;
            r_pix_flush <= 1'b1;
            r_pix_data  <= '0;
            r_fcnt      <= r_fcnt == F_LAST ? '0 : r_fcnt + 1'b1;
            if (r_fcnt == F_LAST) r_state <= DONE;
          end
          DONE: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fast_frame_ctrl.sv
// tb_fast_frame_ctrl: directed bench with a frame-level reference model checked every cycle.
module tb_fast_frame_ctrl;
  localparam int N = 32;
  localparam int F = 5;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [7:0] pix_data;
  logic       pix_ce;
  logic       pix_flush;
  logic       busy;
  logic       frame_done;
  logic       err_len;
  int n_chk = 0;
  int n_err = 0;
  bit armed = 0;
  typedef enum {M_IDLE, M_RUN, M_FLUSH, M_DONE} mode_t;
  mode_t m = M_IDLE;
  int m_n = 0;
  int m_left = 0;
  bit e_ce = 0;
  bit e_fl = 0;
  bit e_err = 0;
  logic [7:0] e_data = 0;
  int q_pix[$];
  int n_fl = 0;
  int n_done = 0;
  int done_nfl = 0;
  bit early_fl = 0;
  fast_frame_ctrl #(.COL_NUM(8), .ROW_NUM(4), .PIXEL_WIDTH(8), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .pix_data(pix_data), .pix_ce(pix_ce), .pix_flush(pix_flush),
    .busy(busy), .frame_done(frame_done), .err_len(err_len)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: frame seen as a count of accepted pixels followed by F flush beats.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m = M_IDLE; m_n = 0; m_left = 0;
        e_ce = 0; e_fl = 0; e_err = 0; e_data = 0;
      end else begin
        e_ce = 0;
        e_fl = 0;
        if (abort) m = M_IDLE;
        else if (m == M_IDLE && start) begin
          m = M_RUN; m_n = 0; e_err = 0;
        end else if (m == M_RUN && s_tvalid) begin
          e_ce = 1; e_data = s_tdata; m_n++;
          if (s_tlast || m_n == N) begin
            if (s_tlast != (m_n == N)) e_err = 1;
            m = M_FLUSH; m_left = F;
          end
        end else if (m == M_FLUSH) begin
          e_ce = 1; e_fl = 1; e_data = 0; m_left--;
          if (m_left == 0) m = M_DONE;
        end else if (m == M_DONE) m = M_IDLE;
      end
      #2;
      if (armed) begin
        chk("pix_ce", 32'(pix_ce), 32'(e_ce));
        chk("pix_flush", 32'(pix_flush), 32'(e_fl));
        chk("pix_data", 32'(pix_data), 32'(e_data));
        chk("s_tready", 32'(s_tready), 32'(m == M_RUN));
        chk("busy", 32'(busy), 32'(m != M_IDLE));
        chk("frame_done", 32'(frame_done), 32'(m == M_DONE));
        chk("err_len", 32'(err_len), 32'(e_err));
        if (pix_ce && !pix_flush) q_pix.push_back(int'(pix_data));
        if (pix_ce && pix_flush) begin
          n_fl++;
          if (q_pix.size() < N) early_fl = 1;
        end
        if (frame_done) begin
          n_done++;
          done_nfl = pix_flush ? n_fl : -1;
        end
      end
    end
  end
  task automatic clr();
    q_pix.delete(); n_fl = 0; n_done = 0; done_nfl = 0; early_fl = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic send(input int n, input int last_at, input bit gaps, input int base, output int acc);
    bit stalled = 0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (gaps && $urandom_range(1) == 1) begin
        s_tvalid = 0;
        @(negedge clk);
      end
      s_tvalid = 1; s_tdata = 8'(i + base); s_tlast = (i == last_at - 1);
      if (!s_tready) begin
        stalled = 1;
        break;
      end
      acc++;
    end
    if (!stalled) @(negedge clk);
    s_tvalid = 0; s_tlast = 0;
  endtask
  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 32'(c < 200), 1);
  endtask
  task automatic seq_ok(input string nm, input int len, input int base);
    int bad = 0;
    chk({nm, "_len"}, q_pix.size(), len);
    foreach (q_pix[i]) if (q_pix[i] != i + base) bad++;
    chk({nm, "_seq"}, bad, 0);
  endtask
  initial begin
    int acc;
    rst_n = 0; start = 0; abort = 0; s_tdata = 0; s_tvalid = 0; s_tlast = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_tready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ce", 32'(pix_ce), 0);
    rst_n = 1;
    armed = 1;
    // nominal frame
    clr(); pulse_start();
    chk("start_busy", 32'(busy), 1);
    send(N, N, 0, 0, acc);
    wait_idle();
    seq_ok("nom", N, 0);
    chk("nom_flush", n_fl, F);
    chk("nom_done", n_done, 1);
    chk("nom_done_at_last_flush", done_nfl, F);
    chk("nom_err", 32'(err_len), 0);
    // random upstream gaps
    clr(); pulse_start();
    send(N, N, 1, 0, acc);
    wait_idle();
    seq_ok("gap", N, 0);
    chk("gap_flush", n_fl, F);
    chk("gap_early_flush", 32'(early_fl), 0);
    // short frame: tlast on pixel value 20
    clr(); pulse_start();
    send(N, 21, 0, 0, acc);
    chk("short_acc", acc, 21);
    wait_idle();
    seq_ok("short", 21, 0);
    chk("short_flush", n_fl, F);
    chk("short_err", 32'(err_len), 1);
    chk("short_done", n_done, 1);
    // long frame: 40 offered, only 32 taken
    clr(); pulse_start();
    send(40, 40, 0, 0, acc);
    chk("long_acc", acc, N);
    chk("long_ready", 32'(s_tready), 0);
    wait_idle();
    seq_ok("long", N, 0);
    chk("long_err", 32'(err_len), 1);
    chk("long_done", n_done, 1);
    pulse_start();
    chk("restart_err_clr", 32'(err_len), 0);
    send(N, N, 0, 0, acc);
    wait_idle();
    // abort after 10 beats
    clr(); pulse_start();
    send(10, 0, 0, 0, acc);
    abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_ready", 32'(s_tready), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (8) @(negedge clk);
    chk("abort_ce_le10", 32'(q_pix.size() <= 10), 1);
    chk("abort_flush", n_fl, 0);
    chk("abort_done", n_done, 0);
    clr(); pulse_start();
    send(N, N, 0, 0, acc);
    wait_idle();
    seq_ok("post_abort", N, 0);
    chk("post_abort_flush", n_fl, F);
    // start during RUN is ignored
    clr(); pulse_start();
    send(10, 0, 0, 0, acc);
    pulse_start();
    send(22, 22, 0, 10, acc);
    wait_idle();
    seq_ok("midstart", N, 0);
    chk("midstart_done", n_done, 1);
    chk("midstart_err", 32'(err_len), 0);
    // start and abort together in IDLE
    @(negedge clk) begin start = 1; abort = 1; end
    @(negedge clk) begin start = 0; abort = 0; end
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_ready", 32'(s_tready), 0);
    // reset mid-FLUSH after a faulty frame so err_len is set
    clr(); pulse_start();
    send(N, 5, 0, 0, acc);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_ce", 32'(pix_ce), 0);
    chk("arst_flush", 32'(pix_flush), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(err_len), 0);
    chk("arst_data", 32'(pix_data), 0);
    chk("arst_done", 32'(frame_done), 0);
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fast_frame_ctrl.md
# fast_frame_ctrl

Frame sequencer in front of the 7x7 line-buffer/window generator of the FAST corner pipeline. It accepts one frame of pixels from the DMA stream with a valid/ready handshake and drives the window generator's pixel input and clock-enable. It checks the frame length against the configured geometry. After the last pixel it flushes the pipeline with zero pixels so that the final rows and corner coordinates drain out, then signals frame completion.

## Interface
Parameters:
- COL_NUM, 640, pixels per row
- ROW_NUM, 480, rows per frame
- PIXEL_WIDTH, 8, pixel bit width
- FLUSH_CYCLES, 1940, zero-pixel beats issued after a frame ends; must be ≥1 and ≥ the downstream drain latency (3*COL_NUM+11 plus margin)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; begins a frame when in IDLE
- abort  in  1  one-cycle pulse; cancels any frame immediately
- s_tdata  in  PIXEL_WIDTH  DMA pixel
- s_tvalid  in  1  DMA beat valid
- s_tlast  in  1  DMA marks last pixel of frame
- s_tready  out  1  controller accepts beat
- pix_data  out  PIXEL_WIDTH  pixel to window generator data_in
- pix_ce  out  1  window generator ce; one pulse per pixel
- pix_flush  out  1  current pix_ce beat is a flush (zero) pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame completion
- err_len  out  1  sticky length error for the current/last frame

## Operation
- Reset values: s_tready=0, pix_data=0, pix_ce=0, pix_flush=0, busy=0, frame_done=0, err_len=0, state=IDLE, all counters 0.
- States: IDLE, RUN, FLUSH, DONE. busy=(state!=IDLE). s_tready=(state==RUN), decoded from the registered state only.
- IDLE: when start=1 and abort=0, clear err_len and the x/y counters, then go to RUN. A start pulse in any other state is ignored.
- RUN: a beat is accepted when s_tvalid&s_tready. x counts 0..COL_NUM-1. When x wraps to 0, y increments. y counts 0..ROW_NUM-1.
- End of frame is an accepted beat with s_tlast=1, or an accepted beat at x=COL_NUM-1 and y=ROW_NUM-1, whichever happens first. Either one moves the state to FLUSH.
- err_len is set on either of these:
  - s_tlast=1 accepted at any position other than the final pixel (short frame);
  - the final pixel is accepted with s_tlast=0 (long frame). Surplus DMA beats are not consumed; s_tready is 0.
- FLUSH: s_tready=0. Issue exactly FLUSH_CYCLES beats with pix_data=0 and pix_flush=1, one per cycle, no gaps. Then go to DONE.
- DONE: frame_done=1 for that one cycle, then return to IDLE.
- abort (any state, highest priority): next state is IDLE. Counters clear and no further pix_ce is issued after the abort cycle's registered output. No frame_done. err_len is kept.
- Width rules: x and y are clog2-sized. The flush counter is clog2(FLUSH_CYCLES+1) bits. All compares are exact; there is no modular overflow.

## Timing
- Outputs pix_data, pix_ce and pix_flush are registered, with 1-cycle latency. A beat accepted in cycle k gives pix_ce=1 and pix_data=s_tdata in cycle k+1.
- If no beat is accepted in cycle k and the state is not FLUSH, then pix_ce=0 and pix_data holds its last value in cycle k+1.
- start sampled in cycle t: busy=1 and s_tready=1 from cycle t+1.
- Last beat accepted in cycle k:
  - FLUSH occupies cycles k+1..k+FLUSH_CYCLES;
  - flush beats appear on pix_ce in cycles k+2..k+FLUSH_CYCLES+1;
  - DONE and frame_done are in cycle k+FLUSH_CYCLES+1, coincident with the last flush beat;
  - IDLE and busy=0 from cycle k+FLUSH_CYCLES+2.
- err_len rises in the cycle after the offending beat. It falls only in the cycle after an accepted start.
- s_tvalid low in RUN stalls the pipeline: no pix_ce. Upstream stalls are never filled with zero beats.
- rst_n asserted mid-frame: all outputs go to their reset values asynchronously. Deassertion returns to IDLE.

## Test plan
Use COL_NUM=8, ROW_NUM=4, FLUSH_CYCLES=5 unless stated otherwise.
- Nominal: start, then 32 back-to-back beats 0..31 with tlast on the 32nd -> pix_ce high 32 cycles carrying 0..31, then 5 zero beats with pix_flush=1; frame_done 1 cycle concurrent with the 5th flush beat; err_len=0; busy low the next cycle.
- Random s_tvalid gaps (~50%) -> pix_data sequence is still exactly 0..31 with no duplicates; pix_ce count is 32+5; no flush beat appears before beat 31.
- Short frame: tlast on beat 20 -> err_len=1 the cycle after; flush begins; 21+5 pix_ce total; frame_done pulses.
- Long frame: 40 beats offered with tlast on the 40th -> only 32 accepted; s_tready=0 from beat 33; err_len=1; frame_done pulses. A following start clears err_len.
- Abort mid-RUN after 10 beats -> s_tready=0 the next cycle; at most 10 pix_ce total; no flush beats; no frame_done; a new start runs a clean 32-beat frame.
- Reset and ignored start: rst_n pulsed low mid-FLUSH -> all outputs 0 immediately. A start during RUN has no effect; start and abort in the same IDLE cycle -> remains IDLE.
